// File: rtl/scratch_arbiter.sv
// Scratch RAM arbiter: memory stage vs stack sequencer, single port.
// Same-cycle grants, one-cycle tagged read returns, starvation and lock.
module scratch_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 10,
  parameter int STARVE_MAX = 3,
  parameter int LOCK_MAX   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic              mem_wait,
  input  logic              stk_req,
  input  logic              stk_we,
  input  logic              stk_lock,
  input  logic [ADDR_W-1:0] stk_addr,
  input  logic [DATA_W-1:0] stk_wdata,
  output logic              stk_gnt,
  output logic              stk_rvalid,
  output logic              stk_wait,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] starve_cnt, starve_nx;
  logic [LW-1:0] lock_cnt, lock_nx;
  logic          rd_pend, rd_owner;
  logic          starved, stk_win, mem_win;

  assign starved = starve_cnt == SW'(STARVE_MAX);

  // STK wins when locked, alone, or starved; MEM otherwise
  assign stk_win = !reset && stk_req &&
                   (state == LOCKED || !mem_req || starved);
  assign mem_win = !reset && mem_req && !stk_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lock_cnt   <= '0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      lock_cnt   <= lock_nx;
      rd_pend    <= (mem_win && !mem_we) ||
                    (stk_win && !stk_we);
      rd_owner   <= stk_win;
    end
  end

  always_comb begin
    state_nx  = state;
    lock_nx   = lock_cnt;
    starve_nx = '0;
    if (stk_req && !stk_win) begin
      starve_nx = starved ? starve_cnt
                          : starve_cnt + SW'(1);
    end
    case (state)
      IDLE: begin
        if (stk_win && stk_lock) begin
          state_nx = LOCKED;
          lock_nx  = '0;
        end
      end
      LOCKED: begin
        if (!stk_req) begin
          state_nx = IDLE;
        end else begin
          lock_nx = lock_cnt + LW'(1);
          if (!stk_lock || lock_nx == LW'(LOCK_MAX))
            state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_gnt   = mem_win;
    stk_gnt   = stk_win;
    mem_wait  = !reset && mem_req && !mem_win;
    stk_wait  = !reset && stk_req && !stk_win;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      stk_win: begin
        ram_we    = stk_we;
        ram_addr  = stk_addr;
        ram_wdata = stk_wdata;
      end
      mem_win: begin
        ram_we    = mem_we;
        ram_addr  = mem_addr;
        ram_wdata = mem_wdata;
      end
      default: ;
    endcase
    mem_rvalid = !reset && rd_pend && !rd_owner;
    stk_rvalid = !reset && rd_pend && rd_owner;
    rd_data    = (mem_rvalid || stk_rvalid) ? ram_rdata
                                            : '0;
  end

endmodule

// File: tb/tb_scratch_arbiter.sv
// Bench for scratch_arbiter: rule-level model checked every cycle,
// plus directed literal expectations for each scenario.
module tb_scratch_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 10;
  localparam int SMAX = 3;
  localparam int LMAX = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req = 1'b0, mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          stk_req = 1'b0, stk_we = 1'b0, stk_lock = 1'b0;
  logic [AW-1:0] stk_addr = '0;
  logic [DW-1:0] stk_wdata = '0;
  logic          mem_gnt, mem_rvalid, mem_wait;
  logic          stk_gnt, stk_rvalid, stk_wait;
  logic [DW-1:0] rd_data, ram_wdata, ram_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;

  logic [DW-1:0] ram_mem [256];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  bit            m_locked = 1'b0;
  int            m_starve = 0;
  int            m_lock = 0;
  bit            m_pend = 1'b0;
  bit            m_pown = 1'b0;
  logic [DW-1:0] m_pdata = '0;
  logic [DW-1:0] shadow [256] = '{default: '0};

  scratch_arbiter dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_wait(mem_wait),
    .stk_req(stk_req), .stk_we(stk_we),
    .stk_lock(stk_lock), .stk_addr(stk_addr),
    .stk_wdata(stk_wdata), .stk_gnt(stk_gnt),
    .stk_rvalid(stk_rvalid), .stk_wait(stk_wait),
    .rd_data(rd_data), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic chk(input string n,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0h exp %0h",
               n, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    logic es, em, wwe, rvm, rvs;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    es = !reset && stk_req &&
         (m_locked || !mem_req || m_starve == SMAX);
    em = !reset && mem_req && !es;
    wwe = es ? stk_we : (em ? mem_we : 1'b0);
    a   = es ? stk_addr : (em ? mem_addr : '0);
    wd  = es ? stk_wdata : (em ? mem_wdata : '0);
    rvm = !reset && m_pend && !m_pown;
    rvs = !reset && m_pend && m_pown;
    chk("mem_gnt", 32'(mem_gnt), 32'(em));
    chk("stk_gnt", 32'(stk_gnt), 32'(es));
    chk("mem_wait", 32'(mem_wait),
        32'(!reset && mem_req && !em));
    chk("stk_wait", 32'(stk_wait),
        32'(!reset && stk_req && !es));
    chk("ram_we", 32'(ram_we), 32'(wwe));
    chk("ram_addr", 32'(ram_addr), 32'(a));
    chk("ram_wdata", 32'(ram_wdata), 32'(wd));
    chk("mem_rvalid", 32'(mem_rvalid), 32'(rvm));
    chk("stk_rvalid", 32'(stk_rvalid), 32'(rvs));
    chk("rd_data", 32'(rd_data),
        32'((rvm || rvs) ? m_pdata : '0));
    if (reset) begin
      m_locked = 1'b0;
      m_starve = 0;
      m_lock   = 0;
      m_pend   = 1'b0;
    end else begin
      m_pend  = (es || em) && !wwe;
      m_pown  = es;
      m_pdata = shadow[a];
      if ((es || em) && wwe) shadow[a] = wd;
      if (stk_req && !es)
        m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      else
        m_starve = 0;
      if (!m_locked) begin
        if (es && stk_lock) begin
          m_locked = 1'b1;
          m_lock   = 0;
        end
      end else if (!stk_req) begin
        m_locked = 1'b0;
      end else begin
        m_lock++;
        if (!stk_lock || m_lock == LMAX) m_locked = 1'b0;
      end
    end
  endtask

  task automatic tick(input logic r,
                      input logic mr, input logic mw,
                      input logic [AW-1:0] ma,
                      input logic [DW-1:0] md,
                      input logic sr, input logic sw,
                      input logic sl,
                      input logic [AW-1:0] sa,
                      input logic [DW-1:0] sd);
    @(posedge clk);
    #1;
    reset = r;
    mem_req = mr; mem_we = mw;
    mem_addr = ma; mem_wdata = md;
    stk_req = sr; stk_we = sw; stk_lock = sl;
    stk_addr = sa; stk_wdata = sd;
    @(negedge clk);
    model_step();
    cyc++;
  endtask

  task automatic idle();
    tick(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  logic [5:0] g2m, g2s, w2s;
  logic [7:0] g3m, g3s, w3m;
  logic [6:0] v6m, v6s;

  initial begin
    tick(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    chk("rst_mem_gnt", 32'(mem_gnt), 32'd0);
    tick(1, 1, 1, 8'h10, 10'h3, 1, 1, 1, 8'h20, 10'h4);
    chk("rst_gnt", 32'({mem_gnt, stk_gnt}), 32'd0);
    chk("rst_wait", 32'({mem_wait, stk_wait}), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);

    // single MEM write then read back
    tick(0, 1, 1, 8'h10, 10'h2A5, 0, 0, 0, '0, '0);
    chk("t1_gnt", 32'(mem_gnt), 32'd1);
    chk("t1_we", 32'(ram_we), 32'd1);
    chk("t1_addr", 32'(ram_addr), 32'h10);
    tick(0, 1, 0, 8'h10, '0, 0, 0, 0, '0, '0);
    idle();
    chk("t1_rvalid", 32'(mem_rvalid), 32'd1);
    chk("t1_rdata", 32'(rd_data), 32'h2A5);

    tick(0, 1, 1, 8'hFF, 10'h155, 0, 0, 0, '0, '0);
    tick(0, 1, 1, 8'hFE, 10'h0AA, 0, 0, 0, '0, '0);
    idle();

    // both requesting, no lock: starvation relief
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 1, 8'h20, 10'(i), 1, 1, 0, 8'h30, 10'(i));
      g2m[i] = mem_gnt;
      g2s[i] = stk_gnt;
      w2s[i] = stk_wait;
    end
    chk("t2_mem_gnt", 32'(g2m), 32'b110111);
    chk("t2_stk_gnt", 32'(g2s), 32'b001000);
    chk("t2_stk_wait", 32'(w2s), 32'b110111);
    idle();

    // locked push burst against MEM
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, 1, 8'h40, 10'(i), 1, 1, 1, 8'h50, 10'(i));
      g3m[i] = mem_gnt;
      g3s[i] = stk_gnt;
      w3m[i] = mem_wait;
    end
    chk("t3_stk_gnt", 32'(g3s), 32'b00111000);
    chk("t3_mem_gnt", 32'(g3m), 32'b11000111);
    chk("t3_mem_wait", 32'(w3m), 32'b00111000);
    idle();

    // STK reads, locked then unlocked
    tick(0, 0, 0, '0, '0, 1, 0, 1, 8'hFF, '0);
    tick(0, 0, 0, '0, '0, 1, 0, 0, 8'hFE, '0);
    chk("t4_rv0", 32'(stk_rvalid), 32'd1);
    chk("t4_rd0", 32'(rd_data), 32'h155);
    chk("t4_mrv0", 32'(mem_rvalid), 32'd0);
    idle();
    chk("t4_rv1", 32'(stk_rvalid), 32'd1);
    chk("t4_rd1", 32'(rd_data), 32'h0AA);
    chk("t4_mrv1", 32'(mem_rvalid), 32'd0);
    idle();
    chk("t4_rv2", 32'(stk_rvalid), 32'd0);

    // reset during lock with a read in flight
    tick(0, 0, 0, '0, '0, 1, 0, 1, 8'hFF, '0);
    tick(0, 1, 0, 8'h10, '0, 1, 0, 1, 8'hFE, '0);
    chk("t5_lock_gnt", 32'({mem_gnt, stk_gnt}), 32'b01);
    tick(1, 1, 0, 8'h10, '0, 1, 0, 1, 8'hFE, '0);
    chk("t5_rst_rv", 32'(stk_rvalid), 32'd0);
    chk("t5_rst_gnt", 32'({mem_gnt, stk_gnt}), 32'd0);
    tick(0, 1, 0, 8'h10, '0, 0, 0, 0, '0, '0);
    chk("t5_mem_gnt", 32'(mem_gnt), 32'd1);
    chk("t5_post_rv", 32'(stk_rvalid), 32'd0);
    idle();
    chk("t5_mrv", 32'(mem_rvalid), 32'd1);
    chk("t5_rd", 32'(rd_data), 32'h2A5);
    idle();

    // alternating readers
    for (int i = 0; i < 7; i++) begin
      if (i == 6)
        idle();
      else if (i % 2 == 0)
        tick(0, 1, 0, 8'h10, '0, 0, 0, 0, '0, '0);
      else
        tick(0, 0, 0, '0, '0, 1, 0, 0, 8'hFF, '0);
      v6m[i] = mem_rvalid;
      v6s[i] = stk_rvalid;
    end
    chk("t6_mrv", 32'(v6m), 32'b0101010);
    chk("t6_srv", 32'(v6s), 32'b1010100);
    chk("t6_rd_last", 32'(rd_data), 32'h155);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
